// File: rtl/vpe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vpe_pkg
//  Purpose  : Shared definitions for the VPE result drain: geometry
//             constants, element / lane types, the FIFO entry record and
//             the drain FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package vpe_pkg;

    localparam int LANES         = 6;
    localparam int TILE          = 128;
    localparam int ELEM_W        = 8;
    localparam int BEAT_ELEMS    = 16;
    localparam int BEATS_PER_VEC = TILE / BEAT_ELEMS;

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W  = TILE * ELEM_W;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [LANE_W-1:0] lane_idx_t;

    // One accepted VPE result. vec is element 0 in the LSBs.
    typedef struct packed {
        lane_idx_t        lane;
        logic             mode;   // 1 = scalar, 0 = vector
        logic [VEC_W-1:0] vec;
        elem_t            scal;
    } drain_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_VEC  = 2'd1,
        SEND_SCAL = 2'd2
    } drain_state_e;

    // Send state a result of the given mode starts in.
    function automatic drain_state_e mode_to_state(input logic mode);
        return mode ? SEND_SCAL : SEND_VEC;
    endfunction

endpackage : vpe_pkg
`default_nettype wire

// File: rtl/vpe_drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vpe_drain_fifo
//  Purpose  : Two-entry FIFO of drain_entry_t with registered occupancy.
//  Ports    : clk_i, rst_i (async, active-high)
//             push_i / push_entry_i  - write an entry (ignored when full)
//             pop_i                  - free the head (ignored when empty)
//             head_o                 - current head entry
//             second_mode_o          - mode of the entry behind the head
//             full_o, empty_o, count_o - occupancy status (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module vpe_drain_fifo
    import vpe_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  drain_entry_t push_entry_i,
    input  logic         pop_i,
    output drain_entry_t head_o,
    output logic         second_mode_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    drain_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (count_q == 2'd2);
    assign empty_o   = (count_q == 2'd0);
    assign count_o   = count_q;
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (w_do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed behind count_q.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o        = mem_q[rd_ptr_q];
    assign second_mode_o = mem_q[~rd_ptr_q].mode;

endmodule : vpe_drain_fifo
`default_nettype wire

// File: rtl/vpe_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : vpe_result_drain
//  Purpose  : Accepts vector/scalar results from the VPE lanes into a
//             2-entry FIFO and streams them out in acceptance order as
//             BEAT_ELEMS-element beats (one beat for a scalar).
//  Ports    : clk_i, rst_i (async, active-high)
//             in_valid_i/in_ready_o, in_lane_i, in_mode_i, in_vec_i,
//             in_scal_i                 - result input handshake
//             out_valid_o/out_ready_i, out_data_o, out_lane_o,
//             out_scal_o, out_last_o    - beat output handshake
//             vec_cnt_o, scal_cnt_o     - only with VPE_DRAIN_CNT_EN
//  Config   : `define VPE_DRAIN_CNT_EN adds the completed-result counters.
//  Note     : FIFO entries use the vpe_pkg geometry; parameter overrides
//             must match the package values.
//  Revision : 1.0 - initial release
// ============================================================================
module vpe_result_drain #(
    parameter int LANES      = vpe_pkg::LANES,
    parameter int TILE       = vpe_pkg::TILE,
    parameter int ELEM_W     = vpe_pkg::ELEM_W,
    parameter int BEAT_ELEMS = vpe_pkg::BEAT_ELEMS
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [$clog2(LANES)-1:0]     in_lane_i,
    input  logic                         in_mode_i,
    input  logic [TILE*ELEM_W-1:0]       in_vec_i,
    input  logic [ELEM_W-1:0]            in_scal_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [BEAT_ELEMS*ELEM_W-1:0] out_data_o,
    output logic [$clog2(LANES)-1:0]     out_lane_o,
    output logic                         out_scal_o,
`ifdef VPE_DRAIN_CNT_EN
    output logic [31:0]                  vec_cnt_o,
    output logic [31:0]                  scal_cnt_o,
`endif
    output logic                         out_last_o
);

    import vpe_pkg::*;

    localparam int c_BEATS  = TILE / BEAT_ELEMS;
    localparam int c_BEAT_W = BEAT_ELEMS * ELEM_W;
    localparam int c_CNT_W  = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

    drain_state_e       state_q;
    logic [c_CNT_W-1:0] beat_q;
    logic               ready_en_q;   // holds in_ready_o low until the first post-reset edge

    drain_entry_t w_push_entry;
    drain_entry_t w_head;
    logic         w_second_mode;
    logic         w_full;
    logic         w_empty;
    logic [1:0]   w_count;
    logic         w_push;
    logic         w_pop;
    logic         w_out_fire;
    logic         w_last_beat;
    logic         w_more_after_pop;
    logic         w_next_mode;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    assign w_push_entry = '{lane: in_lane_i, mode: in_mode_i,
                            vec: in_vec_i, scal: in_scal_i};

    assign in_ready_o = ready_en_q & ~w_full;
    assign w_push     = in_valid_i & in_ready_o;

    vpe_drain_fifo u_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (w_push),
        .push_entry_i  (w_push_entry),
        .pop_i         (w_pop),
        .head_o        (w_head),
        .second_mode_o (w_second_mode),
        .full_o        (w_full),
        .empty_o       (w_empty),
        .count_o       (w_count)
    );

    // ------------------------------------------------------------------
    // Beat sequencing
    // ------------------------------------------------------------------
    assign out_valid_o = (state_q == SEND_VEC) || (state_q == SEND_SCAL);
    assign out_scal_o  = (state_q == SEND_SCAL);
    assign w_last_beat = (state_q == SEND_SCAL) ||
                         ((state_q == SEND_VEC) && (beat_q == c_LAST_BEAT));
    assign out_last_o  = w_last_beat;
    assign w_out_fire  = out_valid_o & out_ready_i;
    assign w_pop       = w_out_fire & w_last_beat;

    // After the head pops, the next head is the second stored entry, or,
    // when only one entry was held, the result being pushed on this edge.
    assign w_more_after_pop = (w_count == 2'd2) | w_push;
    assign w_next_mode      = (w_count == 2'd2) ? w_second_mode : in_mode_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!w_empty) begin
                        state_q <= mode_to_state(w_head.mode);
                    end
                end
                SEND_VEC, SEND_SCAL: begin
                    if (w_out_fire) begin
                        if (w_last_beat) begin
                            beat_q  <= '0;
                            state_q <= w_more_after_pop ? mode_to_state(w_next_mode)
                                                        : IDLE;
                        end else begin
                            beat_q <= beat_q + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output payload: decoded from registered state, forced to zero
    // whenever no beat is presented.
    // ------------------------------------------------------------------
    always_comb begin
        out_data_o = '0;
        out_lane_o = '0;
        if (state_q == SEND_VEC) begin
            out_data_o = w_head.vec[int'(beat_q)*c_BEAT_W +: c_BEAT_W];
            out_lane_o = w_head.lane;
        end else if (state_q == SEND_SCAL) begin
            out_data_o[ELEM_W-1:0] = w_head.scal;
            out_lane_o             = w_head.lane;
        end
    end

`ifdef VPE_DRAIN_CNT_EN
    // ------------------------------------------------------------------
    // Completed-result counters (wrap modulo 2^32)
    // ------------------------------------------------------------------
    logic [31:0] vec_cnt_q;
    logic [31:0] scal_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vec_cnt_q  <= 32'd0;
            scal_cnt_q <= 32'd0;
        end else begin
            if (w_pop && (state_q == SEND_VEC)) begin
                vec_cnt_q <= vec_cnt_q + 32'd1;
            end
            if (w_out_fire && (state_q == SEND_SCAL)) begin
                scal_cnt_q <= scal_cnt_q + 32'd1;
            end
        end
    end

    assign vec_cnt_o  = vec_cnt_q;
    assign scal_cnt_o = scal_cnt_q;
`endif

endmodule : vpe_result_drain
`default_nettype wire

// File: tb/tb_vpe_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vpe_result_drain
//  Purpose  : Self-checking bench for vpe_result_drain. A result-level model
//             (queue of expected beats, occupancy count) is compared with the
//             DUT on every falling edge; directed scenarios add literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vpe_result_drain;

    localparam int LANE_W = 3;
    localparam int VEC_W  = 1024;
    localparam int BEAT_W = 128;
    localparam int BEATS  = 8;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic [LANE_W-1:0] lane;
        logic              scal;
        logic              last;
    } beat_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [LANE_W-1:0] in_lane_i;
    logic              in_mode_i;
    logic [VEC_W-1:0]  in_vec_i;
    logic [7:0]        in_scal_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [BEAT_W-1:0] out_data_o;
    logic [LANE_W-1:0] out_lane_o;
    logic              out_scal_o;
    logic              out_last_o;
`ifdef VPE_DRAIN_CNT_EN
    logic [31:0]       vec_cnt_o;
    logic [31:0]       scal_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    // Model state
    beat_t exp_q[$];
    beat_t log_q[$];     // beats actually transferred by the DUT
    int    occ       = 0;
    bit    fresh     = 0;
    bit    armed     = 0;
    int    vec_done  = 0;
    int    scal_done = 0;
    bit    prev_hold = 0;
    logic [133:0] prev_out;
    bit    push_now, pop_now;
    int    occ_before;
    beat_t b_tmp;
    logic [VEC_W-1:0] tmp_vec;
    bit    rnd_done;

    always #5 clk_i = ~clk_i;

    vpe_result_drain dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_lane_i   (in_lane_i),
        .in_mode_i   (in_mode_i),
        .in_vec_i    (in_vec_i),
        .in_scal_i   (in_scal_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_lane_o  (out_lane_o),
        .out_scal_o  (out_scal_o),
`ifdef VPE_DRAIN_CNT_EN
        .vec_cnt_o   (vec_cnt_o),
        .scal_cnt_o  (scal_cnt_o),
`endif
        .out_last_o  (out_last_o)
    );

    task automatic chk(input bit ok, input string name,
                       input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expand one accepted result into the beats it must produce.
    function automatic void add_result(input logic mode, input logic [LANE_W-1:0] lane,
                                       input logic [VEC_W-1:0] vec, input logic [7:0] scal);
        beat_t b;
        if (mode) begin
            b.data = {120'd0, scal};
            b.lane = lane; b.scal = 1'b1; b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k < BEATS; k++) begin
                b.data = vec[k*BEAT_W +: BEAT_W];
                b.lane = lane; b.scal = 1'b0; b.last = (k == BEATS-1);
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int w = 0; w < VEC_W/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Compare process: outputs against the model, then commit the
    // handshakes that the coming rising edge will perform.
    // ------------------------------------------------------------------
    always @(negedge clk_i) begin
        if (rst_i) begin
            chk({in_ready_o, out_valid_o, out_last_o, out_scal_o, out_lane_o} == '0 &&
                out_data_o == '0, "reset_outputs",
                {in_ready_o, out_valid_o, out_last_o, out_scal_o, out_lane_o, out_data_o}, 0);
`ifdef VPE_DRAIN_CNT_EN
            chk(vec_cnt_o == 0 && scal_cnt_o == 0, "reset_counters",
                {vec_cnt_o, scal_cnt_o}, 0);
`endif
            exp_q.delete();
            occ = 0; fresh = 0; armed = 0; prev_hold = 0;
            vec_done = 0; scal_done = 0;
        end else begin
            chk(in_ready_o == (armed && occ < 2), "in_ready", in_ready_o, (armed && occ < 2));
            chk(out_valid_o == (occ > 0 && !fresh), "out_valid", out_valid_o, (occ > 0 && !fresh));
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", out_data_o, 0);
                end else begin
                    chk(out_data_o == exp_q[0].data, "beat_data", out_data_o, exp_q[0].data);
                    chk({out_lane_o, out_scal_o, out_last_o} ==
                        {exp_q[0].lane, exp_q[0].scal, exp_q[0].last}, "beat_lane_scal_last",
                        {out_lane_o, out_scal_o, out_last_o},
                        {exp_q[0].lane, exp_q[0].scal, exp_q[0].last});
                end
            end
            if (prev_hold) begin
                chk({out_valid_o, out_data_o, out_lane_o, out_scal_o, out_last_o} == prev_out,
                    "stall_stable", {out_valid_o, out_data_o, out_lane_o, out_scal_o, out_last_o},
                    prev_out);
            end
`ifdef VPE_DRAIN_CNT_EN
            chk(vec_cnt_o == vec_done, "vec_cnt", vec_cnt_o, vec_done);
            chk(scal_cnt_o == scal_done, "scal_cnt", scal_cnt_o, scal_done);
`endif
            prev_hold = out_valid_o && !out_ready_i;
            prev_out  = {out_valid_o, out_data_o, out_lane_o, out_scal_o, out_last_o};

            push_now   = in_valid_i && in_ready_o;
            pop_now    = out_valid_o && out_ready_i;
            occ_before = occ;
            if (pop_now) begin
                log_q.push_back('{data: out_data_o, lane: out_lane_o,
                                  scal: out_scal_o, last: out_last_o});
                if (exp_q.size() > 0) begin
                    b_tmp = exp_q.pop_front();
                    if (b_tmp.last) begin
                        occ--;
                        if (b_tmp.scal) scal_done++;
                        else            vec_done++;
                    end
                end
            end
            if (push_now) begin
                add_result(in_mode_i, in_lane_i, in_vec_i, in_scal_i);
                occ++;
            end
            fresh = push_now && (occ_before == 0);
            armed = 1'b1;
        end
    end

    // Call shortly after a rising edge; returns 1 time unit after the
    // accepting edge.
    task automatic push(input logic mode, input logic [LANE_W-1:0] lane,
                        input logic [VEC_W-1:0] vec, input logic [7:0] scal);
        bit got;
        bit done;
        done = 0;
        in_valid_i = 1'b1; in_mode_i = mode; in_lane_i = lane;
        in_vec_i = vec; in_scal_i = scal;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk_i);
            got = in_ready_o;
            @(posedge clk_i);
            if (got) done = 1;
        end
        #1;
        in_valid_i = 1'b0;
        if (!done) chk(1'b0, "push_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int c = 0; c < 4000 && !ok; c++) begin
            @(posedge clk_i);
            #2;
            ok = (occ == 0);
        end
        chk(ok, "drain_timeout", occ, 0);
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int bad;
        logic [7:0] lastmask;
        logic [3:0] pat;
        logic [BEAT_W-1:0] eb;

        rst_i = 1'b1; in_valid_i = 1'b0; in_lane_i = '0; in_mode_i = 1'b0;
        in_vec_i = '0; in_scal_i = '0; out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk(in_ready_o == 1'b0, "ready_before_first_edge", in_ready_o, 0);
        @(posedge clk_i); #1;
        chk(in_ready_o == 1'b1, "ready_after_first_edge", in_ready_o, 1);

        // --- Vector on lane 3, element i = i ---------------------------------
        out_ready_i = 1'b1;
        for (int i = 0; i < 128; i++) tmp_vec[i*8 +: 8] = i[7:0];
        log_q.delete();
        push(1'b0, 3'd3, tmp_vec, 8'h00);
        @(negedge clk_i);
        chk(out_valid_o == 1'b0, "latency_edge1", out_valid_o, 0);
        @(negedge clk_i);
        chk(out_valid_o == 1'b1, "latency_edge2", out_valid_o, 1);
        chk(out_data_o == 128'h0F0E0D0C0B0A09080706050403020100, "vec_beat0_data",
            out_data_o, 128'h0F0E0D0C0B0A09080706050403020100);
        chk(out_lane_o == 3'd3, "vec_lane", out_lane_o, 3);
        wait_drain();
        chk(log_q.size() == 8, "vec_beat_count", log_q.size(), 8);
        lastmask = '0;
        for (int k = 0; k < log_q.size() && k < 8; k++) lastmask[k] = log_q[k].last;
        chk(lastmask == 8'h80, "vec_last_position", lastmask, 8'h80);

        // --- Scalar 0xA5 on lane 5 -------------------------------------------
        log_q.delete();
        push(1'b1, 3'd5, '0, 8'hA5);
        for (int c = 0; c < 10 && !out_valid_o; c++) @(negedge clk_i);
        chk(out_valid_o && out_data_o == 128'hA5 && out_scal_o && out_last_o &&
            out_lane_o == 3'd5, "scalar_beat",
            {out_valid_o, out_scal_o, out_last_o, out_lane_o, out_data_o},
            {1'b1, 1'b1, 1'b1, 3'd5, 128'hA5});
        wait_drain();
        chk(log_q.size() == 1, "scalar_beat_count", log_q.size(), 1);

        // --- Three pushes with the sink stalled --------------------------------
        out_ready_i = 1'b0;
        log_q.delete();
        push(1'b0, 3'd0, rand_vec(), 8'h00);
        push(1'b1, 3'd1, '0, 8'h11);
        fork
            push(1'b0, 3'd2, rand_vec(), 8'h00);
            begin
                repeat (3) @(negedge clk_i);
                chk(in_ready_o == 1'b0, "third_push_stalled", in_ready_o, 0);
                @(posedge clk_i); #1;
                out_ready_i = 1'b1;
            end
        join
        wait_drain();
        chk(log_q.size() == 17, "three_results_beats", log_q.size(), 17);
        bad = 0;
        for (int k = 0; k < log_q.size(); k++) begin
            if (log_q[k].lane != ((k < 8) ? 3'd0 : (k == 8) ? 3'd1 : 3'd2)) bad++;
        end
        chk(bad == 0, "three_results_order", bad, 0);

        // --- out_ready toggling 1,0,0,1 during a vector ------------------------
        out_ready_i = 1'b0;
        log_q.delete();
        for (int i = 0; i < 128; i++) tmp_vec[i*8 +: 8] = i[7:0] ^ 8'h5A;
        push(1'b0, 3'd4, tmp_vec, 8'h00);
        pat = 4'b1001;
        for (int c = 0; c < 200 && occ != 0; c++) begin
            out_ready_i = pat[c % 4];
            @(posedge clk_i); #1;
        end
        out_ready_i = 1'b1;
        wait_drain();
        chk(log_q.size() == 8, "toggle_beat_count", log_q.size(), 8);
        bad = 0;
        for (int k = 0; k < log_q.size(); k++) begin
            for (int j = 0; j < 16; j++) eb[j*8 +: 8] = (k*16 + j) ^ 8'h5A;
            if (log_q[k].data != eb) bad++;
        end
        chk(bad == 0, "toggle_beat_sequence", bad, 0);

        // --- Reset at beat 4 of a vector ---------------------------------------
        log_q.delete();
        push(1'b0, 3'd2, rand_vec(), 8'h00);
        for (int c = 0; c < 100 && log_q.size() < 4; c++) begin
            @(posedge clk_i); #2;
        end
        chk(log_q.size() == 4, "reached_beat4", log_q.size(), 4);
        rst_i = 1'b1;
        #1;
        chk(!out_valid_o && !out_last_o && !out_scal_o && out_lane_o == 0 &&
            out_data_o == 0 && !in_ready_o, "reset_mid_vector",
            {in_ready_o, out_valid_o, out_last_o, out_scal_o, out_lane_o, out_data_o}, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        log_q.delete();
        push(1'b1, 3'd1, '0, 8'h3C);
        wait_drain();
        chk(log_q.size() == 1 && log_q[0].data == 128'h3C && log_q[0].scal,
            "post_reset_first_beat", (log_q.size() > 0) ? log_q[0].data : 128'hDEAD, 128'h3C);

`ifdef VPE_DRAIN_CNT_EN
        // --- Counters: 2 vectors + 3 scalars -----------------------------------
        do_reset();
        out_ready_i = 1'b1;
        push(1'b0, 3'd0, rand_vec(), 8'h00);
        push(1'b1, 3'd1, '0, 8'h01);
        push(1'b1, 3'd2, '0, 8'h02);
        push(1'b0, 3'd3, rand_vec(), 8'h00);
        push(1'b1, 3'd4, '0, 8'h04);
        wait_drain();
        chk(vec_cnt_o == 32'd2 && scal_cnt_o == 32'd3, "counters_2v_3s",
            {vec_cnt_o, scal_cnt_o}, {32'd2, 32'd3});
`endif

        // --- Randomized traffic --------------------------------------------------
        rnd_done = 0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk_i); #1;
                    end
                    push($urandom_range(0, 1) == 1, LANE_W'($urandom_range(0, 5)),
                         rand_vec(), 8'($urandom));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    out_ready_i = ($urandom_range(0, 3) != 0);
                    @(posedge clk_i); #1;
                end
            end
        join
        out_ready_i = 1'b1;
        wait_drain();
        chk(exp_q.size() == 0, "model_empty_at_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vpe_result_drain
`default_nettype wire
